fetch_queue: RTL
================

# fetch_queue

Instruction fetch queue that sits directly upstream of the decode stage. It owns the program counter and issues word reads to a fixed-latency (1-cycle) synchronous instruction memory. It buffers returned instructions with their PC and PC+4 in a small FIFO and presents them to decode through a valid/ready handshake. A `flush` redirect, driven from branch/jump resolution, discards all queued and in-flight instructions and restarts fetch at a new target.

## Interface
- `DATA_WIDTH`, 32, width of PC and instruction words
- `DEPTH`, 4, queue entries; power of two, ≥2
- `RESET_PC`, 32'hBFC0_0000, PC fetched first after reset
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: asynchronous, active-high reset
- `trigger` in 1: fetch enable; low = no new requests, queue still drains
- `flush` in 1: redirect; kills queue contents and in-flight response
- `flush_pc` in DATA_WIDTH: redirect target, sampled when `flush`=1
- `imem_addr` out DATA_WIDTH: read address, equals `pc_q`
- `imem_req` out 1: read issued this cycle; memory always accepts
- `imem_rdata` in DATA_WIDTH: read data, valid exactly one cycle after a request
- `out_valid` out 1: head entry valid for decode
- `out_ready` in 1: decode consumes head when `out_valid`&`out_ready`
- `out_instr` out DATA_WIDTH: head instruction
- `out_pc` out DATA_WIDTH: head PC
- `out_pc4` out DATA_WIDTH: head PC+4

## Operation
- State: `pc_q`, `inflight_q`, `inflight_pc_q`, FIFO storage, `count` (0..DEPTH).
- Issue: `imem_req = trigger & ~flush & (count + inflight_q < DEPTH)`. On issue: `inflight_q`←1, `inflight_pc_q`←`pc_q`, `pc_q`←`pc_q+4` (modulo 2^DATA_WIDTH, wraps silently).
- Response: when `inflight_q`=1 and `flush`=0, push {`inflight_pc_q`, `imem_rdata`}. `inflight_q` clears unless a new request is issued in the same cycle.
- Pop: when `out_valid & out_ready & ~flush`. Push and pop in the same cycle keep `count` unchanged.
- Flush has highest priority. In the flush cycle: `count`←0, the response arriving this cycle is dropped, `inflight_q`←0, `pc_q`←`flush_pc`, and no request is issued. Fetch at `flush_pc` begins the next cycle if enabled.
- `out_pc4` = `out_pc + 4`, computed combinationally from the stored PC.
- Full: the issue gate guarantees a push never occurs at `count`=DEPTH. Violating this is an assertion failure.
- Empty: `out_valid`=0, and `out_*` data is don't-care (holds last head).

## Timing
- Reset (async assert, sync release): `pc_q`=RESET_PC, `inflight_q`=0, `count`=0. Outputs: `imem_req`=0 while `rst`, `imem_addr`=RESET_PC, `out_valid`=0.
- Reset asserted mid-operation discards everything immediately. No partial state survives.
- Latency without bypass: request at cycle n, data in memory at n+1, written to queue, `out_valid` at n+2.
- Latency with bypass: `out_valid` at n+1.
- Steady-state throughput is 1 instruction/cycle when `out_ready`=1 and `trigger`=1.
- `trigger` deasserted: the in-flight response still lands, and requests stop in the same cycle.
- `flush` at cycle f: `out_valid`=0 at f+1. The first `flush_pc` request is at f+1, and its instruction is valid at f+3 without bypass.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when the queue is empty and a response lands, the response drives `out_*` combinationally with `out_valid`=1. If `out_ready`=1 it is consumed without a write; otherwise it is written.
- `FETCH_QUEUE_BYPASS_EN` undefined: every response is written to the queue and is visible the next cycle. No combinational path from `imem_rdata` to `out_*`.

## Structure
- `fetch_pkg`: `fq_entry_t` struct {pc, instr}, `RESET_PC` default constant, `INSTR_BYTES`=4.
- Sub-module `fq_fifo`: parameterised `fq_entry_t` FIFO with push/pop/clear and count.
- `fetch_queue` holds the PC, in-flight tracking, issue gating and bypass mux.

## Test plan
- Reset release, `trigger`=1, `out_ready`=1, memory returns word = addr: `out_pc` sequence 0xBFC00000, …04, …08 at one per cycle; `out_pc4` = PC+4.
- `out_ready`=0 for 10 cycles: exactly DEPTH entries queued, `imem_req` low once `count+inflight`=4, then resume draining in order with no loss or duplicates.
- `flush`=1, `flush_pc`=0x100, with 3 queued and 1 in flight: `out_valid`=0 next cycle. The next delivered PC is 0x100. No stale PC ever appears.
- Flush in the same cycle as push and pop: flush wins, `count`=0, and the popped entry is not counted as consumed.
- `pc_q`=0xFFFFFFFC: next fetch address is 0x00000000.
- Assert `rst` mid-stream: outputs return to reset values immediately. Re-fetch starts at RESET_PC. Run the whole plan with and without `FETCH_QUEUE_BYPASS_EN`, and check the latency difference of 1 cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned FQ_XLEN     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [FQ_XLEN-1:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Small circular FIFO of fetch entries with synchronous clear and an
// occupancy count; the head entry is visible without a read strobe.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fq_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  entry_t      wdata,
  output entry_t      rdata,
  output logic [AW:0] count
);

  entry_t          mem [DEPTH];
  logic   [AW-1:0] wr_ptr;
  logic   [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

  // The issue gate upstream must keep pushes away from a full queue.
  always @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(push && count == (AW+1)'(DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the PC, issues 1-cycle memory reads and
// buffers responses for decode. FETCH_QUEUE_BYPASS_EN enables the empty-queue bypass.
module fetch_queue
  import fetch_pkg::fq_entry_t;
  import fetch_pkg::FQ_XLEN;
  import fetch_pkg::INSTR_BYTES;
#(
  parameter int unsigned           DATA_WIDTH = FQ_XLEN,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_pc,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc4
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_q;
  logic [AW:0]           count;
  logic [AW+1:0]         occupancy;
  logic                  resp;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  fq_entry_t             head;
  fq_entry_t             resp_entry;
  fq_entry_t             sel;

  // Queued entries plus the one in flight must leave room for a new response.
  assign occupancy  = {1'b0, count} + {{(AW+1){1'b0}}, inflight_q};
  assign imem_req   = trigger & ~flush & ~rst & (occupancy < (AW+2)'(DEPTH));
  assign imem_addr  = pc_q;
  assign resp       = inflight_q & ~flush;
  assign fifo_empty = (count == '0);
  assign resp_entry = '{pc: inflight_pc_q, instr: imem_rdata};
  assign fifo_pop   = ~fifo_empty & out_ready & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = resp & fifo_empty;
  assign out_valid = ~fifo_empty | bypass;
  assign sel       = bypass ? resp_entry : head;
  assign fifo_push = resp & ~(bypass & out_ready);
`else
  assign out_valid = ~fifo_empty;
  assign sel       = head;
  assign fifo_push = resp;
`endif

  assign out_pc    = sel.pc;
  assign out_instr = sel.instr;
  assign out_pc4   = sel.pc + DATA_WIDTH'(INSTR_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (flush) begin
      pc_q       <= flush_pc;
      inflight_q <= 1'b0;
    end else if (imem_req) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
      pc_q          <= pc_q + DATA_WIDTH'(INSTR_BYTES);
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fq_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (resp_entry),
    .rdata (head),
    .count (count)
  );

endmodule
